multdiv_hazard_ctrl: RTL and testbench
======================================

# multdiv_hazard_ctrl

Pipeline sequencing controller for the 5-stage processor. It starts the multi-cycle multiplier/divider when a `mul`/`div` reaches Execute and freezes the pipeline until the result is ready. It also detects load-use hazards between the Execute-stage `lw` and the register addresses read by the Decode-stage instruction. It sits beside the decode-stage read-register decoder, consuming its A/B outputs, and drives the pipeline-latch enables and the multdiv control pulses.

## Interface
- MD_TIMEOUT, 40: cycles allowed in BUSY before the watchdog forces completion; range 2..255.
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- d_valid  in  1  Decode stage holds a real (non-bubble) instruction.
- d_rA  in  5  read-register A of the Decode instruction; 0 = no read.
- d_rB  in  5  read-register B of the Decode instruction; 0 = no read.
- x_valid  in  1  Execute stage holds a real instruction.
- x_insn  in  32  Execute instruction. Fields: opcode [31:27], rd [26:22], ALU op [6:2].
- md_ready  in  1  multdiv result-ready strobe.
- md_exc  in  1  multdiv exception (e.g. divide by zero); valid with md_ready.
- md_start_mult  out  1  one-cycle start pulse to the multiplier.
- md_start_div  out  1  one-cycle start pulse to the divider.
- stall_x  out  1  hold PC, F/D and D/X; insert a bubble into X/M.
- stall_fd  out  1  hold PC and F/D (load-use).
- bubble_dx  out  1  load a nop into D/X (load-use).
- md_done  out  1  one-cycle pulse: the X instruction leaves with the multdiv result.
- md_exc_out  out  1  exception flag accompanying md_done.
- md_timeout_err  out  1  sticky watchdog flag; cleared only by reset.
- stall_count  out  32  saturating count of cycles with stall_x or stall_fd high.

## Operation
- Decode: `is_md` = x_valid & opcode==00000 & ALU op ∈ {00110 mul, 00111 div}. `is_lw` = x_valid & opcode==01000.
- FSM states are IDLE, START, BUSY, DONE.
  - IDLE: if `is_md`, go to START and latch the op type.
  - START: pulse md_start_mult or md_start_div (exactly one, from the latched type), then go to BUSY.
  - BUSY: if md_ready, latch md_exc and go to DONE. Else, if the cycle counter reaches MD_TIMEOUT-1, set md_timeout_err, force the latched exception to 1, and go to DONE.
  - DONE: md_done=1 and md_exc_out=latched exception for this cycle only; return to IDLE.
- stall_x = (IDLE & `is_md`) | START | BUSY. It is combinational and low in DONE, so the `mul`/`div` advances exactly once.
- An instruction advancing out of DONE is not restarted: in IDLE the next cycle, X holds the following instruction.
- Load-use hazard = `is_lw` & rd≠0 & d_valid & (rd==d_rA | rd==d_rB).
  - Register 0 never causes a hazard.
  - stall_fd = bubble_dx = hazard & ~stall_x; stall_x takes priority.
- A hazard produces exactly one stall cycle, because the `lw` moves to Memory.
- stall_count increments when stall_x|stall_fd is high and saturates at 0xFFFFFFFF.
- md_ready received in IDLE, START or DONE is ignored.

## Timing
- Reset values: state IDLE, all pulses 0, stall_x 0 (unless the combinational IDLE path fires), md_timeout_err 0, stall_count 0, latched exception 0, cycle counter 0.
- A reset mid-operation abandons the multdiv transaction without a md_done pulse.
- Latency, with `mul` entering X at cycle t:
  - start pulse at t+1.
  - BUSY from t+2.
  - if md_ready is first seen at cycle r (r ≥ t+2), md_done is at r+1 and the pipeline advances at the edge ending r+1.
- Total stall_x cycles = (r+1) − t.
- Watchdog: BUSY lasts at most MD_TIMEOUT cycles, counted from the first BUSY cycle.
- md_ready and the timeout in the same cycle: md_ready wins and md_timeout_err stays 0.
- Load-use hazard and stall_x both asserted: only stall_x is seen. The hazard is re-evaluated after stall_x drops.

## Structure
- Shared package `proc_pkg`:
  - opcode constants OP_ALU=00000, OP_LW=01000;
  - ALU op constants ALU_MUL=00110, ALU_DIV=00111;
  - the MD state enum;
  - instruction field index constants.
- One sub-module, `md_watchdog`: an 8-bit counter with clear/enable and an `expired` output at MD_TIMEOUT-1.
- All other logic lives in the top module.

## Test plan
- `mul` in X with md_ready at its 33rd BUSY cycle → md_start_mult high one cycle at t+1; stall_x high 35 cycles; md_done one cycle; md_exc_out=0; stall_count=35.
- `div` with md_ready & md_exc at the 3rd BUSY cycle → md_start_div only; md_done with md_exc_out=1; md_timeout_err=0.
- `lw $5` in X, Decode reads d_rA=5 → stall_fd=bubble_dx=1 for exactly one cycle. `lw $0` with d_rA=0 → no stall.
- md_ready never asserted, MD_TIMEOUT=40 → md_done after 40 BUSY cycles; md_exc_out=1; md_timeout_err stays 1 until reset.
- Reset asserted during BUSY → next cycle IDLE, all outputs 0, no md_done. A following `mul` restarts cleanly.
- Back-to-back `mul`,`div` → two separate start pulses separated by DONE and IDLE; the first instruction is never restarted.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, field and multdiv state definitions
package proc_pkg;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RD_HI     = 26;
    localparam int RD_LO     = 22;
    localparam int ALUOP_HI  = 6;
    localparam int ALUOP_LO  = 2;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_START,
        MD_BUSY,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/multdiv_hazard_ctrl_if.sv
// rtl/multdiv_hazard_ctrl_if.sv - pipeline/multdiv signal bundle for the sequencing controller
interface multdiv_hazard_ctrl_if;

    logic        d_valid;
    logic [4:0]  d_rA;
    logic [4:0]  d_rB;
    logic        x_valid;
    logic [31:0] x_insn;
    logic        md_ready;
    logic        md_exc;

    logic        md_start_mult;
    logic        md_start_div;
    logic        stall_x;
    logic        stall_fd;
    logic        bubble_dx;
    logic        md_done;
    logic        md_exc_out;
    logic        md_timeout_err;
    logic [31:0] stall_count;

    // Pipeline side: supplies stage contents and multdiv status, consumes controls.
    modport master (
        output d_valid, d_rA, d_rB, x_valid, x_insn, md_ready, md_exc,
        input  md_start_mult, md_start_div, stall_x, stall_fd, bubble_dx,
               md_done, md_exc_out, md_timeout_err, stall_count
    );

    modport slave (
        input  d_valid, d_rA, d_rB, x_valid, x_insn, md_ready, md_exc,
        output md_start_mult, md_start_div, stall_x, stall_fd, bubble_dx,
               md_done, md_exc_out, md_timeout_err, stall_count
    );

endinterface

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - BUSY-cycle counter that flags the last allowed multdiv cycle
module md_watchdog #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(MD_TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multdiv_hazard_ctrl.sv
// rtl/multdiv_hazard_ctrl.sv - multdiv sequencing FSM plus load-use hazard detection
module multdiv_hazard_ctrl
    import proc_pkg::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic                   clock,
    input  logic                   reset,
    multdiv_hazard_ctrl_if.slave   bus
);

    md_state_t   state;
    logic [4:0]  x_opcode;
    logic [4:0]  x_aluop;
    logic [4:0]  x_rd;
    logic        is_md;
    logic        is_mul;
    logic        is_lw;
    logic        hazard;
    logic        stall_x_c;
    logic        expired;
    logic        unused_insn_bits;

    logic        start_mult_q;
    logic        start_div_q;
    logic        done_q;
    logic        exc_out_q;
    logic        timeout_err_q;
    logic [31:0] stall_count_q;

    assign x_opcode = bus.x_insn[OPCODE_HI:OPCODE_LO];
    assign x_aluop  = bus.x_insn[ALUOP_HI:ALUOP_LO];
    assign x_rd     = bus.x_insn[RD_HI:RD_LO];
    assign unused_insn_bits = ^{bus.x_insn[RD_LO-1:ALUOP_HI+1], bus.x_insn[ALUOP_LO-1:0]};

    assign is_mul = (x_aluop == ALU_MUL);
    assign is_md  = bus.x_valid && (x_opcode == OP_ALU) && (is_mul || x_aluop == ALU_DIV);
    assign is_lw  = bus.x_valid && (x_opcode == OP_LW);

    assign hazard = is_lw && (x_rd != 5'd0) && bus.d_valid &&
                    ((x_rd == bus.d_rA) || (x_rd == bus.d_rB));

    // Low in DONE so the mul/div leaves X exactly once.
    assign stall_x_c = ((state == MD_IDLE) && is_md) || (state == MD_START) || (state == MD_BUSY);

    md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != MD_BUSY),
        .enable  (state == MD_BUSY),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= MD_IDLE;
            start_mult_q  <= 1'b0;
            start_div_q   <= 1'b0;
            done_q        <= 1'b0;
            exc_out_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            done_q       <= 1'b0;
            exc_out_q    <= 1'b0;

            if ((stall_x_c || hazard) && stall_count_q != 32'hFFFF_FFFF) begin
                stall_count_q <= stall_count_q + 32'd1;
            end

            case (state)
                MD_IDLE: begin
                    if (is_md) begin
                        // The start flops double as the latched op type for the START cycle.
                        state        <= MD_START;
                        start_mult_q <= is_mul;
                        start_div_q  <= !is_mul;
                    end
                end
                MD_START: begin
                    state <= MD_BUSY;
                end
                MD_BUSY: begin
                    if (bus.md_ready) begin
                        state     <= MD_DONE;
                        done_q    <= 1'b1;
                        exc_out_q <= bus.md_exc;
                    end else if (expired) begin
                        state         <= MD_DONE;
                        done_q        <= 1'b1;
                        exc_out_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_x        = stall_x_c;
    assign bus.stall_fd       = hazard && !stall_x_c;
    assign bus.bubble_dx      = hazard && !stall_x_c;
    assign bus.md_start_mult  = start_mult_q;
    assign bus.md_start_div   = start_div_q;
    assign bus.md_done        = done_q;
    assign bus.md_exc_out     = exc_out_q;
    assign bus.md_timeout_err = timeout_err_q;
    assign bus.stall_count    = stall_count_q;

endmodule

// File: tb/tb_multdiv_hazard_ctrl.sv
// tb/tb_multdiv_hazard_ctrl.sv - directed and random checks against a transaction-level reference
module tb_multdiv_hazard_ctrl;

    localparam int TO = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_hazard_ctrl_if bus ();

    multdiv_hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: one outstanding mul/div tracked by age since it entered X.
    bit     m_live = 0;
    bit     m_act  = 0;
    int     m_age  = 0;
    int     m_busy = 0;
    bit     m_fin  = 0;
    bit     m_fin_exc = 0;
    bit     m_div  = 0;
    bit     m_terr = 0;
    longint m_cnt  = 0;
    bit     exp_sx_last = 0;

    int n_sx, n_fd, n_sm, n_sd, n_done;
    bit last_exc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_obs();
        n_sx = 0; n_fd = 0; n_sm = 0; n_sd = 0; n_done = 0; last_exc = 0;
    endtask

    function automatic bit dec_md(input logic v, input logic [31:0] i);
        return v && i[31:27] == 5'd0 && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
        logic [31:0] i;
        i = $urandom;
        i[31:27] = op;
        i[26:22] = rd;
        i[6:2]   = alu;
        return i;
    endfunction

    task automatic step();
        bit e_sx, e_sm, e_sd, e_done, e_exc, e_fd, haz, md_now;
        logic [4:0] rd;
        @(negedge clock);
        md_now = dec_md(bus.x_valid, bus.x_insn);
        rd = bus.x_insn[26:22];
        e_sx = 0; e_sm = 0; e_sd = 0; e_done = 0; e_exc = 0;
        if (!m_act) begin
            e_sx = md_now;
        end else if (m_age == 1) begin
            e_sx = 1; e_sm = !m_div; e_sd = m_div;
        end else if (m_fin) begin
            e_done = 1; e_exc = m_fin_exc;
        end else begin
            e_sx = 1;
        end
        haz = bus.x_valid && bus.x_insn[31:27] == 5'b01000 && rd != 5'd0 && bus.d_valid &&
              (rd == bus.d_rA || rd == bus.d_rB);
        e_fd = haz && !e_sx;
        exp_sx_last = e_sx;
        if (m_live) begin
            chk("stall_x", 32'(bus.stall_x), 32'(e_sx));
            chk("stall_fd", 32'(bus.stall_fd), 32'(e_fd));
            chk("bubble_dx", 32'(bus.bubble_dx), 32'(e_fd));
            chk("start_mult", 32'(bus.md_start_mult), 32'(e_sm));
            chk("start_div", 32'(bus.md_start_div), 32'(e_sd));
            chk("md_done", 32'(bus.md_done), 32'(e_done));
            chk("md_exc_out", 32'(bus.md_exc_out), 32'(e_exc));
            chk("timeout_err", 32'(bus.md_timeout_err), 32'(m_terr));
            chk("stall_count", bus.stall_count, 32'(m_cnt));
        end
        n_sx += int'(bus.stall_x);
        n_fd += int'(bus.stall_fd);
        n_sm += int'(bus.md_start_mult);
        n_sd += int'(bus.md_start_div);
        n_done += int'(bus.md_done);
        if (bus.md_done) last_exc = bus.md_exc_out;
        @(posedge clock);
        if (reset) begin
            m_live = 1; m_act = 0; m_terr = 0; m_cnt = 0; m_fin = 0;
        end else if (m_live) begin
            if ((e_sx || e_fd) && m_cnt != 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (!m_act) begin
                if (md_now) begin
                    m_act = 1; m_age = 1; m_fin = 0; m_busy = 0;
                    m_div = (bus.x_insn[6:2] == 5'd7);
                end
            end else if (m_fin) begin
                m_act = 0; m_fin = 0;
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                if (bus.md_ready) begin
                    m_fin = 1; m_fin_exc = bus.md_exc;
                end else if (m_busy == TO - 1) begin
                    m_fin = 1; m_fin_exc = 1; m_terr = 1;
                end
                m_busy++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; bus.x_valid = 0; bus.md_ready = 0; bus.md_exc = 0;
        step(); step();
        reset = 0;
    endtask

    // ready_at: BUSY cycle (1-based) on which md_ready is raised; 0 = never.
    task automatic run_md(input bit dv, input int ready_at, input bit exc);
        bus.x_valid = 1;
        bus.x_insn  = mk(5'd0, 5'($urandom_range(1, 31)), dv ? 5'd7 : 5'd6);
        bus.d_valid = 0;
        step();
        step();
        for (int b = 1; b <= 300 && !m_fin; b++) begin
            bus.md_ready = (b == ready_at);
            bus.md_exc   = exc && (b == ready_at);
            step();
        end
        bus.md_ready = 0; bus.md_exc = 0;
        step();
    endtask

    initial begin
        bit hold;
        int r;
        bus.d_valid = 0; bus.d_rA = 0; bus.d_rB = 0; bus.x_valid = 0;
        bus.x_insn = 0; bus.md_ready = 0; bus.md_exc = 0;
        do_reset();

        clr_obs();
        run_md(0, 33, 0);
        bus.x_valid = 0; step();
        chk("t1_stall_cycles", 32'(n_sx), 32'd35);
        chk("t1_start_mult", 32'(n_sm), 32'd1);
        chk("t1_start_div", 32'(n_sd), 32'd0);
        chk("t1_done", 32'(n_done), 32'd1);
        chk("t1_exc", 32'(last_exc), 32'd0);
        chk("t1_stall_count", bus.stall_count, 32'd35);

        clr_obs();
        run_md(1, 3, 1);
        bus.x_valid = 0; step();
        chk("t2_start_div", 32'(n_sd), 32'd1);
        chk("t2_start_mult", 32'(n_sm), 32'd0);
        chk("t2_done", 32'(n_done), 32'd1);
        chk("t2_exc", 32'(last_exc), 32'd1);
        chk("t2_terr", 32'(bus.md_timeout_err), 32'd0);

        clr_obs();
        bus.x_valid = 1; bus.x_insn = mk(5'b01000, 5'd5, 5'($urandom));
        bus.d_valid = 1; bus.d_rA = 5; bus.d_rB = 5'($urandom_range(6, 31));
        step();
        bus.x_valid = 0; step();
        chk("t3_lw5_stall", 32'(n_fd), 32'd1);
        bus.x_valid = 1; bus.x_insn = mk(5'b01000, 5'd0, 5'($urandom));
        bus.d_rA = 0; bus.d_rB = 0;
        step();
        bus.x_valid = 0; step();
        chk("t3_lw0_nostall", 32'(n_fd), 32'd1);
        bus.x_valid = 1; bus.x_insn = mk(5'b01000, 5'd9, 5'($urandom));
        bus.d_rA = 3; bus.d_rB = 9;
        step();
        bus.x_valid = 0; step();
        chk("t3_rb_stall", 32'(n_fd), 32'd2);
        bus.d_valid = 0;

        clr_obs();
        run_md(0, 0, 0);
        bus.x_valid = 0; step(); step();
        chk("t4_done", 32'(n_done), 32'd1);
        chk("t4_exc", 32'(last_exc), 32'd1);
        chk("t4_terr_sticky", 32'(bus.md_timeout_err), 32'd1);
        chk("t4_stall_cycles", 32'(n_sx), 32'(TO + 2));
        do_reset();
        chk("t4_terr_cleared", 32'(bus.md_timeout_err), 32'd0);

        clr_obs();
        bus.x_valid = 1; bus.x_insn = mk(5'd0, 5'd7, 5'd6);
        step(); step();
        for (int i = 0; i < 5; i++) step();
        reset = 1; bus.x_valid = 0; step();
        reset = 0; step(); step();
        chk("t5_no_done", 32'(n_done), 32'd0);
        chk("t5_idle_stall", 32'(bus.stall_x), 32'd0);
        chk("t5_count_zero", bus.stall_count, 32'd0);
        clr_obs();
        run_md(0, 2, 0);
        bus.x_valid = 0; step();
        chk("t5_restart_start", 32'(n_sm), 32'd1);
        chk("t5_restart_done", 32'(n_done), 32'd1);

        clr_obs();
        run_md(0, 1, 0);
        run_md(1, 2, 0);
        bus.x_valid = 0; step();
        chk("t6_start_mult", 32'(n_sm), 32'd1);
        chk("t6_start_div", 32'(n_sd), 32'd1);
        chk("t6_done", 32'(n_done), 32'd2);
        chk("t6_stall_cycles", 32'(n_sx), 32'd7);

        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!hold) begin
                r = $urandom_range(0, 9);
                bus.x_valid = (r < 8);
                case (r)
                    0, 1:    bus.x_insn = mk(5'd0, 5'($urandom_range(0, 7)), 5'd6);
                    2:       bus.x_insn = mk(5'd0, 5'($urandom_range(0, 7)), 5'd7);
                    3, 4:    bus.x_insn = mk(5'b01000, 5'($urandom_range(0, 7)), 5'($urandom));
                    default: bus.x_insn = $urandom;
                endcase
            end
            bus.d_valid  = ($urandom_range(0, 3) != 0);
            bus.d_rA     = 5'($urandom_range(0, 7));
            bus.d_rB     = 5'($urandom_range(0, 7));
            bus.md_ready = ($urandom_range(0, 5) == 0);
            bus.md_exc   = 1'($urandom);
            reset        = ($urandom_range(0, 199) == 0);
            step();
            hold = exp_sx_last;
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
